// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register write-back entry type.
// Used by reg_file, decode and the write-back path.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ENC_W  = 2;
    localparam int NREG   = 4;

    typedef struct packed {
        logic              valid;
        logic [ENC_W-1:0]  enc;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [NREG-1:0] enc_onehot(input logic [ENC_W-1:0] e);
        logic [NREG-1:0] oh;
        oh    = '0;
        oh[e] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular write queue: up to two pushes and one pop per cycle.
// Entry array is exposed so the owner can search in-flight writes.
module wb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 push0,
    input  cpu_pkg::wb_entry_t                   push0_entry,
    input  logic                                 push1,
    input  cpu_pkg::wb_entry_t                   push1_entry,
    input  logic                                 pop,
    output cpu_pkg::wb_entry_t                   head_entry,
    output logic [$clog2(DEPTH):0]               count,
    output logic [$clog2(DEPTH)-1:0]             head,
    output cpu_pkg::wb_entry_t [DEPTH-1:0]       entries
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] tail;
    logic [PW-1:0] tail1;
    logic [PW:0]   nxt_count;

    assign tail1      = tail + PW'(1);
    assign head_entry = entries[head];
    assign nxt_count  = count + (PW+1)'(push0) + (PW+1)'(push1)
                        - (PW+1)'(pop);

    // Push slots never alias the head while it is still occupied
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PW'(1);
            end
            if (push0) entries[tail]  <= push0_entry;
            if (push1) entries[tail1] <= push1_entry;
            tail  <= tail + PW'(push0) + PW'(push1);
            count <= nxt_count;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-side driver for reg_file: merges ALU and load writes in order,
// drains one per cycle, and exports pending bits and forwarding.
module reg_writeback #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ENC_W  = cpu_pkg::ENC_W,
    parameter int NREG   = cpu_pkg::NREG,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_valid,
    input  logic [ENC_W-1:0]  ld_enc,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              alu_valid,
    input  logic [ENC_W-1:0]  alu_enc,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic              we,
    output logic [ENC_W-1:0]  r_write_enc,
    output logic [DATA_W-1:0] wdata,
    output logic [NREG-1:0]   pending,
    input  logic [ENC_W-1:0]  fwd_enc,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    wb_entry_t               push0_entry;
    wb_entry_t               push1_entry;
    wb_entry_t               head_entry;
    wb_entry_t [DEPTH-1:0]   entries;
    wb_entry_t [DEPTH-1:0]   aged;
    logic [PW:0]             count;
    logic [PW:0]             free;
    logic [PW-1:0]           head;
    logic                    ld_push;
    logic                    alu_push;
    logic                    push0;
    logic                    push1;
    logic                    pop;

    // A pop in the same cycle does not free a slot for pushes
    assign free      = DEPTH_C - count;
    assign ld_ready  = (free != '0);
    assign alu_ready = (free >= (PW+1)'(2)) || ((free != '0) && !ld_valid);

    assign ld_push  = ld_valid && ld_ready;
    assign alu_push = alu_valid && alu_ready;
    assign pop      = (count != '0);

    // Load is the older instruction, so it takes the first slot
    always_comb begin
        push0       = ld_push || alu_push;
        push1       = ld_push && alu_push;
        push1_entry = '{valid: 1'b1, enc: alu_enc, data: alu_data};
        if (ld_push)
            push0_entry = '{valid: 1'b1, enc: ld_enc, data: ld_data};
        else
            push0_entry = push1_entry;
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push0      (push0),
        .push0_entry(push0_entry),
        .push1      (push1),
        .push1_entry(push1_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count),
        .head       (head),
        .entries    (entries)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we          <= 1'b0;
            r_write_enc <= '0;
            wdata       <= '0;
        end else if (pop) begin
            we          <= 1'b1;
            r_write_enc <= head_entry.enc;
            wdata       <= head_entry.data;
        end else begin
            we <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (entries[i].valid)
                pending = pending | enc_onehot(entries[i].enc);
        if (we)
            pending = pending | enc_onehot(r_write_enc);
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            aged[k] = entries[head + PW'(k)];
    end

    // Oldest first so the youngest matching write wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (we && (r_write_enc == fwd_enc)) begin
            fwd_hit  = 1'b1;
            fwd_data = wdata;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (aged[k].valid && (aged[k].enc == fwd_enc)) begin
                fwd_hit  = 1'b1;
                fwd_data = aged[k].data;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a small reg_file model.
module tb_reg_writeback;

    logic        clk;
    logic        resetn;
    logic        ld_valid;
    logic [1:0]  ld_enc;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        alu_valid;
    logic [1:0]  alu_enc;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        we;
    logic [1:0]  r_write_enc;
    logic [31:0] wdata;
    logic [3:0]  pending;
    logic [1:0]  fwd_enc;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [4];
    logic [33:0] expq [$];
    logic        mon_en = 1'b0;

    reg_writeback dut (
        .clk        (clk),
        .resetn     (resetn),
        .ld_valid   (ld_valid),
        .ld_enc     (ld_enc),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .alu_valid  (alu_valid),
        .alu_enc    (alu_enc),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .we         (we),
        .r_write_enc(r_write_enc),
        .wdata      (wdata),
        .pending    (pending),
        .fwd_enc    (fwd_enc),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) rf[i] <= 32'd3;
        end else if (we) begin
            rf[r_write_enc] <= wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && resetn && we) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_extra: got %0h/%0h expected none",
                         r_write_enc, wdata);
            end else begin
                logic [33:0] e;
                e = expq.pop_front();
                chk("wr_order", {30'd0, r_write_enc}, {30'd0, e[33:32]});
                chk("wr_data", wdata, e[31:0]);
            end
        end
    end

    typedef struct {
        logic        lv;
        logic [1:0]  le;
        logic [31:0] ld;
        logic        av;
        logic [1:0]  ae;
        logic [31:0] ad;
        logic [1:0]  fe;
        logic        lr;
        logic        ar;
        logic        we;
        logic [1:0]  wenc;
        logic [31:0] wd;
        logic [3:0]  pend;
        logic        hit;
        logic [31:0] fd;
    } vec_t;

    vec_t vecs [16];

    task automatic drive(input logic lv, input logic [1:0] le,
                         input logic [31:0] ld, input logic av,
                         input logic [1:0] ae, input logic [31:0] ad);
        ld_valid  = lv;
        ld_enc    = le;
        ld_data   = ld;
        alu_valid = av;
        alu_enc   = ae;
        alu_data  = ad;
    endtask

    initial begin
        //          lv le ld     av ae ad     fe lr ar we wenc wd    pend    hit fd
        vecs[0]  = '{0, 0, 0,     0, 0, 0,     2, 1, 1, 0, 0,   0,    4'h0, 0, 0};
        vecs[1]  = '{0, 0, 0,     1, 0, 10,    0, 1, 1, 0, 0,   0,    4'h0, 0, 0};
        vecs[2]  = '{0, 0, 0,     0, 0, 0,     0, 1, 1, 0, 0,   0,    4'h1, 1, 10};
        vecs[3]  = '{0, 0, 0,     0, 0, 0,     0, 1, 1, 1, 0,   10,   4'h1, 1, 10};
        vecs[4]  = '{0, 0, 0,     0, 0, 0,     2, 1, 1, 0, 0,   10,   4'h0, 0, 0};
        vecs[5]  = '{1, 1, 20,    1, 1, 30,    1, 1, 1, 0, 0,   10,   4'h0, 0, 0};
        vecs[6]  = '{0, 0, 0,     0, 0, 0,     1, 1, 1, 0, 0,   10,   4'h2, 1, 30};
        vecs[7]  = '{0, 0, 0,     0, 0, 0,     1, 1, 1, 1, 1,   20,   4'h2, 1, 30};
        vecs[8]  = '{0, 0, 0,     0, 0, 0,     1, 1, 1, 1, 1,   30,   4'h2, 1, 30};
        vecs[9]  = '{0, 0, 0,     0, 0, 0,     1, 1, 1, 0, 1,   30,   4'h0, 0, 0};
        vecs[10] = '{1, 2, 5,     1, 3, 6,     3, 1, 1, 0, 1,   30,   4'h0, 0, 0};
        vecs[11] = '{1, 3, 7,     0, 0, 0,     3, 1, 1, 0, 1,   30,   4'hC, 1, 6};
        vecs[12] = '{0, 0, 0,     0, 0, 0,     3, 1, 1, 1, 2,   5,    4'hC, 1, 7};
        vecs[13] = '{0, 0, 0,     0, 0, 0,     2, 1, 1, 1, 3,   6,    4'h8, 0, 0};
        vecs[14] = '{0, 0, 0,     0, 0, 0,     3, 1, 1, 1, 3,   7,    4'h8, 1, 7};
        vecs[15] = '{0, 0, 0,     0, 0, 0,     3, 1, 1, 0, 3,   7,    4'h0, 0, 0};

        resetn  = 1'b0;
        fwd_enc = 2'd0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_pend", {28'd0, pending}, 32'd0);
        chk("rst_ldr", {31'd0, ld_ready}, 32'd1);
        chk("rst_alur", {31'd0, alu_ready}, 32'd1);
        chk("rst_hit", {31'd0, fwd_hit}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int v = 0; v < 16; v++) begin
            drive(vecs[v].lv, vecs[v].le, vecs[v].ld,
                  vecs[v].av, vecs[v].ae, vecs[v].ad);
            fwd_enc = vecs[v].fe;
            #1;
            chk($sformatf("v%0d_ldr", v), {31'd0, ld_ready}, {31'd0, vecs[v].lr});
            chk($sformatf("v%0d_alur", v), {31'd0, alu_ready}, {31'd0, vecs[v].ar});
            chk($sformatf("v%0d_we", v), {31'd0, we}, {31'd0, vecs[v].we});
            chk($sformatf("v%0d_wenc", v), {30'd0, r_write_enc}, {30'd0, vecs[v].wenc});
            chk($sformatf("v%0d_wdata", v), wdata, vecs[v].wd);
            chk($sformatf("v%0d_pend", v), {28'd0, pending}, {28'd0, vecs[v].pend});
            chk($sformatf("v%0d_hit", v), {31'd0, fwd_hit}, {31'd0, vecs[v].hit});
            chk($sformatf("v%0d_fdata", v), fwd_data, vecs[v].fd);
            @(posedge clk);
            #1;
        end
        chk("rf_r0", rf[0], 32'd10);
        chk("rf_r1", rf[1], 32'd30);
        chk("rf_r2", rf[2], 32'd5);
        chk("rf_r3", rf[3], 32'd7);

        // Sustained dual-producer traffic
        begin
            logic [31:0] ln;
            logic [31:0] an;
            logic        throttled;
            logic        la;
            logic        aa;
            ln        = 32'd100;
            an        = 32'd200;
            throttled = 1'b0;
            mon_en    = 1'b1;
            for (int c = 0; c < 10; c++) begin
                drive(1, ln[1:0], ln, 1, an[1:0], an);
                #1;
                if (!alu_ready) throttled = 1'b1;
                la = ld_ready;
                aa = alu_ready;
                if (la) expq.push_back({ln[1:0], ln});
                if (aa) expq.push_back({an[1:0], an});
                @(posedge clk);
                #1;
                if (la) ln = ln + 32'd1;
                if (aa) an = an + 32'd1;
            end
            chk("sat_throttle", {31'd0, throttled}, 32'd1);
            drive(0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 20 && expq.size() != 0; c++) begin
                @(posedge clk);
                #1;
            end
            @(posedge clk);
            #1;
            chk("sat_drained", expq.size(), 32'd0);
            chk("sat_idle_we", {31'd0, we}, 32'd0);
        end

        // free == 1 with both producers valid
        drive(1, 0, 32'h11, 1, 1, 32'h22);
        #1;
        expq.push_back({2'd0, 32'h11});
        expq.push_back({2'd1, 32'h22});
        @(posedge clk);
        #1;
        drive(1, 2, 32'h33, 1, 3, 32'h44);
        #1;
        expq.push_back({2'd2, 32'h33});
        expq.push_back({2'd3, 32'h44});
        @(posedge clk);
        #1;
        drive(1, 0, 32'h55, 1, 1, 32'h66);
        #1;
        chk("f1_ldr", {31'd0, ld_ready}, 32'd1);
        chk("f1_alur", {31'd0, alu_ready}, 32'd0);
        expq.push_back({2'd0, 32'h55});
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 1, 32'h66);
        #1;
        chk("f1_alu_next", {31'd0, alu_ready}, 32'd1);
        expq.push_back({2'd1, 32'h66});
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);

        // Reset with three entries still queued
        chk("pre_rst_pend", {31'd0, (pending != 4'h0)}, 32'd1);
        mon_en = 1'b0;
        resetn = 1'b0;
        expq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mr_we", {31'd0, we}, 32'd0);
        chk("mr_pend", {28'd0, pending}, 32'd0);
        chk("mr_ldr", {31'd0, ld_ready}, 32'd1);
        chk("mr_alur", {31'd0, alu_ready}, 32'd1);
        chk("mr_r0", rf[0], 32'd3);
        chk("mr_r1", rf[1], 32'd3);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_we", {31'd0, we}, 32'd0);
        chk("post_rst_hit", {31'd0, fwd_hit}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
